// File: rtl/avg_ser_pkg.sv
// Shared types and constants for the averaged-sample serial framer.
// Frame length depends on AVG_SER_PARITY_EN.
package avg_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_e;

  localparam int unsigned DATA_W = 6;

`ifdef AVG_SER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // start + data + optional parity + stop
  localparam int unsigned FRAME_BITS = DATA_W + PARITY_BITS + 2;

  localparam int unsigned X_LSB = 0;
  localparam int unsigned Y_LSB = 2;
  localparam int unsigned T_LSB = 4;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return (^word[T_LSB +: 2]) ^ (^word[Y_LSB +: 2]) ^ (^word[X_LSB +: 2]);
  endfunction

endpackage

// File: rtl/avg_ser_fifo.sv
// Small synchronous FIFO buffering averaged words ahead of the serial framer.
// Pointer wrap relies on FIFO_DEPTH being a power of two.
module avg_ser_fifo #(
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/avg_frame_serializer.sv
// Buffers averaged {t,y,x} words and shifts them out as async serial frames.
// Parity bit present only when AVG_SER_PARITY_EN is defined.
module avg_frame_serializer
  import avg_ser_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DATA_W       = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  ser_state_e        state;
  logic [7:0]        baud_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              last_tick;
`ifdef AVG_SER_PARITY_EN
  logic              par_q;
`endif

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign last_tick = (baud_cnt == 8'(CLKS_PER_BIT - 1));
  // STOP pops on its final tick so the next START follows with no idle cycle.
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && last_tick));

  avg_ser_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(in_data),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
`ifdef AVG_SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      // Every transition happens on last_tick, so the wrap doubles as the entry reset.
      if (state != IDLE) baud_cnt <= last_tick ? '0 : baud_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (pop) begin
            shift_q <= fifo_head;
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
`ifdef AVG_SER_PARITY_EN
            par_q   <= even_parity(fifo_head);
`endif
          end
        end
        START: begin
          if (last_tick) begin
            state   <= DATA;
            tx      <= shift_q[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (last_tick) begin
            if (bit_cnt == 3'(DATA_W - 1)) begin
`ifdef AVG_SER_PARITY_EN
              state <= PARITY;
              tx    <= par_q;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
            end
          end
        end
`ifdef AVG_SER_PARITY_EN
        PARITY: begin
          if (last_tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (last_tick) begin
            if (pop) begin
              shift_q <= fifo_head;
              state   <= START;
              tx      <= 1'b0;
`ifdef AVG_SER_PARITY_EN
              par_q   <= even_parity(fifo_head);
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                       overflow <= 1'b0;
    else if (in_valid && !in_ready)  overflow <= 1'b1;
  end

endmodule

// File: tb/tb_avg_frame_serializer.sv
// Self-checking bench for avg_frame_serializer: vector table plus a serial
// frame monitor popping expected words from a scoreboard queue.
module tb_avg_frame_serializer;
  import avg_ser_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLEN  = FRAME_BITS * CPB;

  logic       clk;
  logic       rst_n;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int epoch = 0;
  int frames = 0;
  logic [5:0] sb_q[$];
  int         start_cyc[$];

  typedef struct {
    logic [5:0] data;
    logic       exp_ready;
    logic [2:0] exp_count;
    logic       exp_ovf;
  } vec_t;
  vec_t tbl[6];

  avg_frame_serializer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .DATA_W      (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decodes one frame per falling edge of tx, sampling mid-bit on negedges.
  always begin : mon_blk
    logic [5:0] w;
    logic [5:0] e;
    logic       st;
    logic       sp;
    logic       pb;
    int         ep;
    @(negedge tx);
    ep = epoch;
    start_cyc.push_back(cyc);
    pb = 1'b0;
    repeat (CPB / 2 + 1) @(negedge clk);
    st = tx;
    for (int i = 0; i < 6; i++) begin
      repeat (CPB) @(negedge clk);
      w[i] = tx;
    end
`ifdef AVG_SER_PARITY_EN
    repeat (CPB) @(negedge clk);
    pb = tx;
`endif
    repeat (CPB) @(negedge clk);
    sp = tx;
    if (ep == epoch) begin
      frames++;
      check("start_bit", {31'd0, st}, 32'd0);
      check("stop_bit", {31'd0, sp}, 32'd1);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got=%0h expected=none", w);
      end else begin
        e = sb_q.pop_front();
        check("frame_data", {26'd0, w}, {26'd0, e});
`ifdef AVG_SER_PARITY_EN
        check("parity_bit", {31'd0, pb}, {31'd0, ^e});
`else
        if (pb !== 1'b0) $display("monitor parity slot unexpectedly sampled");
`endif
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0 || fifo_count !== 3'd0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s: got=timeout expected=drained (queued=%0d)", name, sb_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_table(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tbl[i].data;
      check("tbl_in_ready", {31'd0, in_ready}, {31'd0, tbl[i].exp_ready});
      if (tbl[i].exp_ready) sb_q.push_back(tbl[i].data);
      @(posedge clk);
      #1;
      check("tbl_fifo_count", {29'd0, fifo_count}, {29'd0, tbl[i].exp_count});
      check("tbl_overflow", {31'd0, overflow}, {31'd0, tbl[i].exp_ovf});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    int dur;
    int f0;
    logic err;

    tbl[0] = '{6'h2D, 1'b1, 3'd1, 1'b0};
    tbl[1] = '{6'h12, 1'b1, 3'd1, 1'b0};
    tbl[2] = '{6'h3F, 1'b1, 3'd2, 1'b0};
    tbl[3] = '{6'h00, 1'b1, 3'd3, 1'b0};
    tbl[4] = '{6'h15, 1'b1, 3'd4, 1'b0};
    tbl[5] = '{6'h2A, 1'b0, 3'd4, 1'b1};

    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    #2 rst_n = 1'b1;
    #3;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;

    // idle for 100 cycles
    err = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) err = 1'b1;
    end
    check("idle_quiet", {31'd0, err}, 32'd0);

    // single word: latency and frame duration
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 6'b101101;
    sb_q.push_back(6'b101101);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", lat, 2);
    dur = 0;
    while (busy === 1'b1 && dur < 200) begin
      dur++;
      @(negedge clk);
    end
    check("busy_duration", dur, FLEN);
    wait_drain("single_drain");
    check("single_frames", frames, 1);

    // five consecutive words: back-to-back frames, no overflow
    start_cyc.delete();
    f0 = frames;
    run_table(5);
    wait_drain("five_drain");
    check("five_frames", frames - f0, 5);
    check("five_overflow", {31'd0, overflow}, 32'd0);
    check("five_starts", start_cyc.size(), 5);
    for (int i = 1; i < start_cyc.size(); i++)
      check("b2b_gap", start_cyc[i] - start_cyc[i-1], FLEN);

    // six consecutive words: last dropped, overflow sticky
    f0 = frames;
    run_table(6);
    wait_drain("six_drain");
    check("six_frames", frames - f0, 5);
    check("six_overflow_sticky", {31'd0, overflow}, 32'd1);

    // reset mid-DATA
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 6'h2D;
    sb_q.push_back(6'h2D);
    @(negedge clk);
    in_data  = 6'h1E;
    sb_q.push_back(6'h1E);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("mid_start_seen", {31'd0, tx}, 32'd0);
    repeat (CPB * 2 + 1) @(negedge clk);
    #1;
    epoch++;
    sb_q.delete();
    rst_n = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (50) @(negedge clk);
    f0 = frames;
    in_valid = 1'b1;
    in_data  = 6'h33;
    sb_q.push_back(6'h33);
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain("post_rst_drain");
    check("post_rst_frames", frames - f0, 1);

    // in_valid low with toggling / unknown data
    f0 = frames;
    err = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i % 7 == 3) in_data = 'x;
      else            in_data = 6'($urandom);
      if (fifo_count !== 3'd0 || tx !== 1'b1 || busy !== 1'b0) err = 1'b1;
    end
    in_data = '0;
    repeat (5) @(negedge clk);
    check("novalid_quiet", {31'd0, err}, 32'd0);
    check("novalid_frames", frames - f0, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avg_frame_serializer.md
# avg_frame_serializer

Downstream stage of the 2-bit x/y/t moving-average filter. It accepts each averaged 6-bit sample word {t,y,x} when the filter's output is qualified, buffers words in a small FIFO, and shifts them out on a single pin as asynchronous serial frames: start bit, 6 data bits LSB first, optional parity, stop bit. It decouples filter output rate from the slow off-chip link and flags dropped words.

## Interface
- CLKS_PER_BIT, default 4: clk cycles per serial bit; legal range 1..255.
- FIFO_DEPTH, default 4: word slots; power of two, 2..16.
- DATA_W, default 6: word width; fixed by the filter output {t[1:0],y[1:0],x[1:0]}.

- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high.
- in_data  input  DATA_W  averaged word, filter output bits [5:0].
- in_valid  input  1  word qualified: filter enable field == 2'b11.
- in_ready  output  1  FIFO not full.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (state != IDLE).
- overflow  output  1  sticky: a word was offered while the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0, in_ready=1. FSM=IDLE, FIFO empty, bit and baud counters 0.
- Push: occurs when in_valid && in_ready. in_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
- Full FIFO: in_ready is low even if a pop happens in the same cycle. The offered word is dropped and overflow sets. overflow clears only on reset.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty, pop the head into the shift register and enter START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] and shift right every CLKS_PER_BIT cycles. After DATA_W bits go to PARITY, or to STOP if parity is compiled out.
- PARITY: tx = even parity (XOR) of the 6 data bits, for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then, if FIFO non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state entry.
- Reset asserted mid-frame: the frame is abandoned, tx=1 immediately (asynchronous), FIFO contents are discarded.
- in_data is ignored when in_valid=0. X on in_data with in_valid=0 must not propagate.

## Timing
- Push at edge E0 raises fifo_count after E0. If IDLE, the pop happens at E1 and tx falls after E1: 2 cycles from accept to start bit.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is 9·CLKS_PER_BIT cycles with parity, 8·CLKS_PER_BIT without.
- Back-to-back frames: the next start bit begins in the cycle after the last stop-bit cycle.
- tx, busy and overflow are registered. in_ready is combinational from registered state.
- Throughput: one word per frame. A sustained in_valid overflows after FIFO_DEPTH+1 words when CLKS_PER_BIT ≥ 1.

## Configuration
- AVG_SER_PARITY_EN defined: PARITY state present, even parity bit between data and stop, 9-bit frame.
- AVG_SER_PARITY_EN undefined: PARITY state and parity logic absent, DATA goes to STOP, 8-bit frame.

## Structure
- Package avg_ser_pkg holds:
  - the state enum;
  - DATA_W (6);
  - FRAME_BITS, derived from AVG_SER_PARITY_EN;
  - the field offsets X_LSB=0, Y_LSB=2, T_LSB=4.
- One sub-module, avg_ser_fifo: a synchronous FIFO with push, pop, head data, count and full/empty flags, parameterised by DATA_W and FIFO_DEPTH.
- The top level contains the FSM, baud counter, shift register and overflow flag.

## Test plan
- Reset then idle, CLKS_PER_BIT=4: tx stays 1, busy=0, in_ready=1 for 100 cycles.
- Single word 6'b101101 offered once: tx falls 2 cycles after accept. Bits 1,0,1,1,0,1 then parity 0 (parity build) then stop 1, each 4 cycles. busy drops after 36 cycles (32 without parity).
- Five words pushed on consecutive cycles with FIFO_DEPTH=4: the first is popped at once, the remaining four are queued. All five frames emit back-to-back with no idle gap, and overflow stays 0.
- Six consecutive words: in_ready goes low, the sixth is dropped, and overflow=1 persists until reset. Five frames are output.
- Reset asserted in the middle of DATA: tx=1 and fifo_count=0 asynchronously. After release the next pushed word produces a clean frame.
- in_valid held 0 while in_data toggles randomly: no frames, fifo_count stays 0.
